uart_rx: RTL and testbench

Configurable UART receiver, the receive end of the serial link timed by the baud rate generator. It takes a single-cycle oversampling strobe at OVERSAMPLE × baud and samples the asynchronous rx line mid-bit. It also checks parity and stop bits, and presents each received frame through a valid/ready holding register to the host side.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_rx.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data-width selection and
// the parity helper that the transmitter will also use.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam logic [1:0] DATA_BITS_5 = 2'b00;
   localparam logic [1:0] DATA_BITS_6 = 2'b01;
   localparam logic [1:0] DATA_BITS_7 = 2'b10;
   localparam logic [1:0] DATA_BITS_8 = 2'b11;

   function automatic logic [3:0] data_bits_count(input logic [1:0] sel);
      logic [3:0] n;
      case (sel)
         DATA_BITS_5: n = 4'd5;
         DATA_BITS_6: n = 4'd6;
         DATA_BITS_7: n = 4'd7;
         default:     n = 4'd8;
      endcase
      return n;
   endfunction

   // Parity over the low nbits of data; odd selects odd parity.
   function automatic logic parity_bit(input logic [7:0] data,
                                       input logic [3:0] nbits,
                                       input logic       odd);
      logic acc;
      acc = odd;
      for (int i = 0; i < 8; i++) begin
         if (4'(i) < nbits) begin
            acc = acc ^ data[i];
         end
      end
      return acc;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx line, plus the
// previous-sample register used for start-bit falling-edge detection.
module uart_rx_sync
   import uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rx_s,
   output logic fall_edge
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Flops reset to the idle-high line level so reset never fakes a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rx_s      = sync_q[SYNC_STAGES-1];
   assign fall_edge = prev_q & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled mid-bit sampling with configurable frame format,
// parity/stop checking and a valid/ready holding register toward the host.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_tick,
   input  logic       rx,
   input  logic [1:0] data_bits_sel,
   input  logic       parity_en,
   input  logic       parity_odd,
   input  logic       stop2,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun_err,
   output logic       busy
);

   localparam int             TW        = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0]  TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0]  HALF_LAST = TW'(OVERSAMPLE / 2 - 1);

   logic          rx_s;
   logic          fall_edge;

   rx_state_t     state_q;
   rx_state_t     state_next;
   logic [TW-1:0] tick_cnt;
   logic [3:0]    bit_cnt;
   logic [7:0]    data_q;
   logic [3:0]    nbits_q;
   logic          par_en_q;
   logic          par_odd_q;
   logic          stop2_q;
   logic          par_err_pend;
   logic          frame_err_pend;

   logic          tick_clr;
   logic          tick_inc;
   logic          bit_clr;
   logic          bit_inc;
   logic          latch_cfg;
   logic          cap_data;
   logic          cap_parity;
   logic          cap_stop;
   logic          frame_done;
   logic          at_half;
   logic          at_full;
   logic          frame_err_final;

   uart_rx_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_s      (rx_s),
      .fall_edge (fall_edge)
   );

   assign at_half = sample_tick && (tick_cnt == HALF_LAST);
   assign at_full = sample_tick && (tick_cnt == TICK_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_next;
      end
   end

   // Next-state logic and datapath strobes; counters only move on ticks.
   always_comb begin
      state_next = state_q;
      tick_clr   = 1'b0;
      tick_inc   = 1'b0;
      bit_clr    = 1'b0;
      bit_inc    = 1'b0;
      latch_cfg  = 1'b0;
      cap_data   = 1'b0;
      cap_parity = 1'b0;
      cap_stop   = 1'b0;
      frame_done = 1'b0;

      case (state_q)
         IDLE: begin
            if (fall_edge) begin
               state_next = START;
               tick_clr   = 1'b1;
               latch_cfg  = 1'b1;
            end
         end
         START: begin
            if (at_half) begin
               tick_clr = 1'b1;
               bit_clr  = 1'b1;
               state_next = rx_s ? IDLE : DATA;
            end else if (sample_tick) begin
               tick_inc = 1'b1;
            end
         end
         DATA: begin
            if (at_full) begin
               tick_clr = 1'b1;
               cap_data = 1'b1;
               if (bit_cnt == nbits_q - 4'd1) begin
                  bit_clr    = 1'b1;
                  state_next = par_en_q ? PARITY : STOP;
               end else begin
                  bit_inc = 1'b1;
               end
            end else if (sample_tick) begin
               tick_inc = 1'b1;
            end
         end
         PARITY: begin
            if (at_full) begin
               tick_clr   = 1'b1;
               cap_parity = 1'b1;
               bit_clr    = 1'b1;
               state_next = STOP;
            end else if (sample_tick) begin
               tick_inc = 1'b1;
            end
         end
         STOP: begin
            if (at_full) begin
               tick_clr = 1'b1;
               cap_stop = 1'b1;
               if (stop2_q && (bit_cnt == 4'd0)) begin
                  bit_inc = 1'b1;
               end else begin
                  frame_done = 1'b1;
                  state_next = IDLE;
               end
            end else if (sample_tick) begin
               tick_inc = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt       <= '0;
         bit_cnt        <= '0;
         data_q         <= '0;
         nbits_q        <= 4'd8;
         par_en_q       <= 1'b0;
         par_odd_q      <= 1'b0;
         stop2_q        <= 1'b0;
         par_err_pend   <= 1'b0;
         frame_err_pend <= 1'b0;
      end else begin
         if (tick_clr) begin
            tick_cnt <= '0;
         end else if (tick_inc) begin
            tick_cnt <= tick_cnt + 1'b1;
         end

         if (bit_clr) begin
            bit_cnt <= '0;
         end else if (bit_inc) begin
            bit_cnt <= bit_cnt + 4'd1;
         end

         if (latch_cfg) begin
            nbits_q        <= data_bits_count(data_bits_sel);
            par_en_q       <= parity_en;
            par_odd_q      <= parity_odd;
            stop2_q        <= stop2;
            data_q         <= '0;
            par_err_pend   <= 1'b0;
            frame_err_pend <= 1'b0;
         end

         if (cap_data) begin
            data_q[bit_cnt[2:0]] <= rx_s;
         end

         if (cap_parity && (rx_s != parity_bit(data_q, nbits_q, par_odd_q))) begin
            par_err_pend <= 1'b1;
         end

         if (cap_stop && !rx_s) begin
            frame_err_pend <= 1'b1;
         end
      end
   end

   // The final stop sample lands in the same cycle as the load, so fold it in.
   assign frame_err_final = frame_err_pend | ~rx_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         overrun_err <= 1'b0;
         if (frame_done && (!rx_valid || rx_ready)) begin
            rx_data    <= data_q;
            parity_err <= par_err_pend;
            frame_err  <= frame_err_final;
            rx_valid   <= 1'b1;
         end else begin
            if (frame_done) begin
               overrun_err <= 1'b1;
            end
            if (rx_valid && rx_ready) begin
               rx_valid <= 1'b0;
            end
         end
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of frame formats plus hand-written
// sequences for latency, break, glitch, overrun and mid-frame reset.
module tb_uart_rx;

   localparam int OS       = 16;
   localparam int BIT_CLKS = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sample_tick;
   logic       rx = 1'b1;
   logic [1:0] data_bits_sel = 2'b11;
   logic       parity_en = 1'b0;
   logic       parity_odd = 1'b0;
   logic       stop2 = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       parity_err;
   logic       frame_err;
   logic       overrun_err;
   logic       busy;

   logic [1:0] tick_div = 2'd0;
   int         checks = 0;
   int         errors = 0;
   int         overrun_cnt = 0;

   typedef struct {
      logic [7:0] data;
      logic [1:0] sel;
      logic       pen;
      logic       podd;
      logic       st2;
      logic       pbit;
      logic       s1;
      logic       s2;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[9];

   uart_rx #(
      .OVERSAMPLE  (OS),
      .SYNC_STAGES (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .sample_tick   (sample_tick),
      .rx            (rx),
      .data_bits_sel (data_bits_sel),
      .parity_en     (parity_en),
      .parity_odd    (parity_odd),
      .stop2         (stop2),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .parity_err    (parity_err),
      .frame_err     (frame_err),
      .overrun_err   (overrun_err),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // One tick every 4 clocks gives 64 clocks per bit at OVERSAMPLE=16.
   always @(posedge clk) tick_div <= tick_div + 2'd1;
   assign sample_tick = (tick_div == 2'd3);

   always @(negedge clk) begin
      if (overrun_err) overrun_cnt++;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called on a negedge; leaves rx at endl after the last stop bit.
   task automatic applyStimulus(input logic [7:0] d, input int nbits, input logic pen,
                                input logic pbit, input logic st2, input logic s1,
                                input logic s2, input logic endl);
      rx = 1'b0;
      waitClk(BIT_CLKS);
      for (int i = 0; i < nbits; i++) begin
         rx = d[i];
         waitClk(BIT_CLKS);
      end
      if (pen) begin
         rx = pbit;
         waitClk(BIT_CLKS);
      end
      rx = s1;
      waitClk(BIT_CLKS);
      if (st2) begin
         rx = s2;
         waitClk(BIT_CLKS);
      end
      rx = endl;
   endtask

   task automatic setCfg(input logic [1:0] sel, input logic pen, input logic podd, input logic st2);
      data_bits_sel = sel;
      parity_en     = pen;
      parity_odd    = podd;
      stop2         = st2;
   endtask

   task automatic acceptFrame(input string name);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      checkOutput({name, " valid cleared"}, 32'(rx_valid), 32'd0);
   endtask

   initial begin
      bit   saw_busy;
      bit   saw_valid;
      bit   found;
      int   ticks;
      int   ov_before;

      vecs[0] = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{8'h41, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0};
      vecs[2] = '{8'h41, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0};
      vecs[3] = '{8'h1F, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b1};
      vecs[4] = '{8'h2A, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0};
      vecs[5] = '{8'h00, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[6] = '{8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};
      vecs[7] = '{8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b0};
      vecs[8] = '{8'hB6, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hB6, 1'b0, 1'b0};

      waitClk(5);
      checkOutput("reset rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset rx_data", 32'(rx_data), 32'd0);
      checkOutput("reset parity_err", 32'(parity_err), 32'd0);
      checkOutput("reset frame_err", 32'(frame_err), 32'd0);
      checkOutput("reset overrun_err", 32'(overrun_err), 32'd0);
      rst = 1'b0;
      waitClk(10);

      // 8N1 0xA5 with latency: stop mid-sample is tick 152 after start detection.
      setCfg(2'b11, 1'b0, 1'b0, 1'b0);
      found = 1'b0;
      fork
         applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
         begin
            repeat (3) @(posedge clk);
            ticks = 0;
            for (int c = 0; c < 2000 && !found; c++) begin
               @(negedge clk);
               if (sample_tick) begin
                  ticks++;
                  if (ticks == 152) begin
                     checkOutput("latency valid before stop tick", 32'(rx_valid), 32'd0);
                     @(posedge clk);
                     #1;
                     checkOutput("latency valid after stop tick", 32'(rx_valid), 32'd1);
                     found = 1'b1;
                  end
               end
            end
         end
      join
      checkOutput("latency stop tick reached", 32'(found), 32'd1);
      checkOutput("8N1 rx_data", 32'(rx_data), 32'hA5);
      acceptFrame("8N1");
      waitClk(16);

      for (int v = 0; v < 9; v++) begin
         setCfg(vecs[v].sel, vecs[v].pen, vecs[v].podd, vecs[v].st2);
         applyStimulus(vecs[v].data, 5 + int'(vecs[v].sel), vecs[v].pen, vecs[v].pbit,
                       vecs[v].st2, vecs[v].s1, vecs[v].s2, 1'b1);
         checkOutput($sformatf("vec%0d rx_valid", v), 32'(rx_valid), 32'd1);
         checkOutput($sformatf("vec%0d rx_data", v), 32'(rx_data), 32'(vecs[v].exp_data));
         checkOutput($sformatf("vec%0d parity_err", v), 32'(parity_err), 32'(vecs[v].exp_perr));
         checkOutput($sformatf("vec%0d frame_err", v), 32'(frame_err), 32'(vecs[v].exp_ferr));
         acceptFrame($sformatf("vec%0d", v));
         waitClk(16);
      end

      // 5N2 with bad second stop, then line held low (break) for 3 bit times.
      setCfg(2'b00, 1'b0, 1'b0, 1'b1);
      applyStimulus(8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("break rx_data", 32'(rx_data), 32'h1F);
      checkOutput("break frame_err", 32'(frame_err), 32'd1);
      acceptFrame("break");
      saw_busy = 1'b0;
      saw_valid = 1'b0;
      for (int c = 0; c < 3 * BIT_CLKS; c++) begin
         @(negedge clk);
         saw_busy  |= busy;
         saw_valid |= rx_valid;
      end
      checkOutput("break no busy", 32'(saw_busy), 32'd0);
      checkOutput("break no valid", 32'(saw_valid), 32'd0);
      rx = 1'b1;
      waitClk(BIT_CLKS);

      // Glitch of 3 ticks: false start, busy pulses then clears.
      setCfg(2'b11, 1'b0, 1'b0, 1'b0);
      rx = 1'b0;
      waitClk(12);
      rx = 1'b1;
      saw_busy = 1'b0;
      saw_valid = 1'b0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         saw_busy  |= busy;
         saw_valid |= rx_valid;
      end
      checkOutput("glitch busy seen", 32'(saw_busy), 32'd1);
      checkOutput("glitch no valid", 32'(saw_valid), 32'd0);
      checkOutput("glitch busy cleared", 32'(busy), 32'd0);
      waitClk(16);

      // Back-to-back 0x11, 0x22 with consumer stalled.
      ov_before = overrun_cnt;
      applyStimulus(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      applyStimulus(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("overrun rx_valid", 32'(rx_valid), 32'd1);
      checkOutput("overrun held data", 32'(rx_data), 32'h11);
      checkOutput("overrun pulse count", 32'(overrun_cnt - ov_before), 32'd1);
      acceptFrame("overrun");
      checkOutput("overrun data after accept", 32'(rx_data), 32'h11);
      waitClk(16);

      // Reset in the middle of data bit 2 of 0x55.
      rx = 1'b0;
      waitClk(BIT_CLKS);
      rx = 1'b1;
      waitClk(BIT_CLKS);
      rx = 1'b0;
      waitClk(BIT_CLKS);
      rx = 1'b1;
      waitClk(BIT_CLKS / 2);
      checkOutput("pre-reset busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midreset rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("midreset busy", 32'(busy), 32'd0);
      checkOutput("midreset rx_data", 32'(rx_data), 32'd0);
      checkOutput("midreset parity_err", 32'(parity_err), 32'd0);
      checkOutput("midreset frame_err", 32'(frame_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      saw_valid = 1'b0;
      for (int c = 0; c < 6 * BIT_CLKS; c++) begin
         @(negedge clk);
         saw_valid |= rx_valid;
      end
      checkOutput("midreset nothing delivered", 32'(saw_valid), 32'd0);
      applyStimulus(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("post-reset rx_valid", 32'(rx_valid), 32'd1);
      checkOutput("post-reset rx_data", 32'(rx_data), 32'h3C);
      checkOutput("post-reset frame_err", 32'(frame_err), 32'd0);
      acceptFrame("post-reset");
      waitClk(16);

      checkOutput("total overrun pulses", 32'(overrun_cnt), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
